// File: rtl/uart_duplex_param.sv
// uart_duplex_param
//   Parametrised full-duplex UART. The receive and transmit halves run
//   independently and share only the clock and reset.
//   The receiver deserialises RX_BITS-wide instruction frames.
//   The transmitter serialises TX_BITS-wide response frames.
//   An optional parity bit follows the data bits in both directions.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   rx             serial input, idle high, asynchronous to clk
//   rx_data        last good received word, LSB received first
//   rx_valid       1-cycle pulse, rx_data just updated
//   rx_frame_err   1-cycle pulse, stop bit sampled low
//   rx_parity_err  1-cycle pulse, parity mismatch with a good stop bit
//   tx_start       send request, honoured only while tx_busy is low
//   tx_data        word to send, captured on the accepted tx_start
//   tx             serial output, idle high, registered
//   tx_busy        frame in progress
//   tx_done        1-cycle pulse as the stop bit completes
module uart_duplex_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int RX_BITS    = 15,
  parameter int TX_BITS    = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_frame_err,
  output logic               rx_parity_err,
  input  logic               tx_start,
  input  logic [TX_BITS-1:0] tx_data,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RX_IDX_W = $clog2(RX_BITS + 1);
  localparam int TX_IDX_W = $clog2(TX_BITS + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  // The transmit stop bit ends one count early: the cycle spent back in IDLE
  // is its final cycle, so a start accepted there follows with no gap.
  localparam logic [CNT_W-1:0]    CNT_STOP = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [RX_IDX_W-1:0] RX_LAST  = RX_IDX_W'(RX_BITS - 1);
  localparam logic [TX_IDX_W-1:0] TX_LAST  = TX_IDX_W'(TX_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic rx_parity(input logic [RX_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  function automatic logic tx_parity(input logic [TX_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // Receive path
  logic                rx_meta, rx_sync;
  state_t              rx_state, rx_state_nxt;
  logic [CNT_W-1:0]    rx_cnt, rx_cnt_nxt;
  logic [RX_IDX_W-1:0] rx_idx, rx_idx_nxt;
  logic [RX_BITS-1:0]  rx_shreg, rx_shreg_nxt, rx_data_nxt;
  logic [RX_BITS:0]    rx_cat;
  logic                rx_par_bad, rx_par_bad_nxt;
  logic                rx_valid_nxt, rx_frame_err_nxt, rx_parity_err_nxt;

  // New bit enters at the MSB so the first received bit ends up at bit 0.
  assign rx_cat = {rx_sync, rx_shreg};

  always_comb begin
    rx_state_nxt      = rx_state;
    rx_cnt_nxt        = rx_cnt + 1'b1;
    rx_idx_nxt        = rx_idx;
    rx_shreg_nxt      = rx_shreg;
    rx_par_bad_nxt    = rx_par_bad;
    rx_data_nxt       = rx_data;
    rx_valid_nxt      = 1'b0;
    rx_frame_err_nxt  = 1'b0;
    rx_parity_err_nxt = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        if (!rx_sync) rx_state_nxt = S_START;
      end
      S_START: if (rx_cnt == CNT_HALF) begin
        rx_cnt_nxt   = '0;
        rx_idx_nxt   = '0;
        rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == CNT_LAST) begin
        rx_cnt_nxt   = '0;
        rx_shreg_nxt = rx_cat[RX_BITS:1];
        if (rx_idx == RX_LAST) begin
          rx_par_bad_nxt = 1'b0;
          rx_state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          rx_idx_nxt = rx_idx + 1'b1;
        end
      end
      S_PARITY: if (rx_cnt == CNT_LAST) begin
        rx_cnt_nxt     = '0;
        rx_par_bad_nxt = rx_sync ^ rx_parity(rx_shreg);
        rx_state_nxt   = S_STOP;
      end
      S_STOP: if (rx_cnt == CNT_LAST) begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = S_IDLE;
        if (!rx_sync)       rx_frame_err_nxt  = 1'b1;
        else if (rx_par_bad) rx_parity_err_nxt = 1'b1;
        else begin
          rx_data_nxt  = rx_shreg;
          rx_valid_nxt = 1'b1;
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_state      <= rx_state_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_idx        <= rx_idx_nxt;
      rx_par_bad    <= rx_par_bad_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_frame_err  <= rx_frame_err_nxt;
      rx_parity_err <= rx_parity_err_nxt;
    end
  end

  always_ff @(posedge clk) rx_shreg <= rx_shreg_nxt;

  // Transmit path
  state_t              tx_state, tx_state_nxt;
  logic [CNT_W-1:0]    tx_cnt, tx_cnt_nxt;
  logic [TX_IDX_W-1:0] tx_idx, tx_idx_nxt;
  logic [TX_BITS-1:0]  tx_shreg, tx_shreg_nxt, tx_shifted;
  logic                tx_par, tx_par_nxt;
  logic                tx_nxt, tx_busy_nxt, tx_done_nxt;

  assign tx_shifted = tx_shreg >> 1;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + 1'b1;
    tx_idx_nxt   = tx_idx;
    tx_shreg_nxt = tx_shreg;
    tx_par_nxt   = tx_par;
    tx_nxt       = tx;
    tx_busy_nxt  = tx_busy;
    tx_done_nxt  = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt = '0;
        if (tx_start) begin
          tx_shreg_nxt = tx_data;
          tx_par_nxt   = tx_parity(tx_data);
          tx_nxt       = 1'b0;
          tx_busy_nxt  = 1'b1;
          tx_state_nxt = S_START;
        end
      end
      S_START: if (tx_cnt == CNT_LAST) begin
        tx_cnt_nxt   = '0;
        tx_idx_nxt   = '0;
        tx_nxt       = tx_shreg[0];
        tx_state_nxt = S_DATA;
      end
      S_DATA: if (tx_cnt == CNT_LAST) begin
        tx_cnt_nxt = '0;
        if (tx_idx == TX_LAST) begin
          tx_nxt       = PARITY_EN ? tx_par : 1'b1;
          tx_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          tx_shreg_nxt = tx_shifted;
          tx_nxt       = tx_shifted[0];
          tx_idx_nxt   = tx_idx + 1'b1;
        end
      end
      S_PARITY: if (tx_cnt == CNT_LAST) begin
        tx_cnt_nxt   = '0;
        tx_nxt       = 1'b1;
        tx_state_nxt = S_STOP;
      end
      S_STOP: if (tx_cnt == CNT_STOP) begin
        tx_cnt_nxt   = '0;
        tx_done_nxt  = 1'b1;
        tx_busy_nxt  = 1'b0;
        tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx       <= tx_nxt;
      tx_busy  <= tx_busy_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_shreg <= tx_shreg_nxt;
    tx_par   <= tx_par_nxt;
  end

endmodule

// File: tb/tb_uart_duplex_param.sv
// Testbench for uart_duplex_param.
// Two instances share clock and reset:
//   dut_d uses the default parameters.
//   dut_p has even parity enabled and 16 clocks per bit.
module tb_uart_duplex_param;

  localparam int CD = 50_000_000 / 115_200;   // 434 clocks per bit
  localparam int CP = 50_000_000 / 3_125_000; // 16 clocks per bit

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset_n;
  logic        rx_d, rx_p;
  logic [14:0] rx_data_d, rx_data_p;
  logic        rx_valid_d, rx_valid_p, rx_frame_err_d, rx_frame_err_p;
  logic        rx_parity_err_d, rx_parity_err_p;
  logic        tx_start_d, tx_start_p;
  logic [7:0]  tx_data_d, tx_data_p;
  logic        tx_d, tx_p, tx_busy_d, tx_busy_p, tx_done_d, tx_done_p;

  uart_duplex_param dut_d (
    .clk(clk), .reset_n(reset_n), .rx(rx_d), .rx_data(rx_data_d),
    .rx_valid(rx_valid_d), .rx_frame_err(rx_frame_err_d),
    .rx_parity_err(rx_parity_err_d), .tx_start(tx_start_d),
    .tx_data(tx_data_d), .tx(tx_d), .tx_busy(tx_busy_d), .tx_done(tx_done_d));

  uart_duplex_param #(.BAUD(3_125_000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .reset_n(reset_n), .rx(rx_p), .rx_data(rx_data_p),
    .rx_valid(rx_valid_p), .rx_frame_err(rx_frame_err_p),
    .rx_parity_err(rx_parity_err_p), .tx_start(tx_start_p),
    .tx_data(tx_data_p), .tx(tx_p), .tx_busy(tx_busy_p), .tx_done(tx_done_p));

  int ntest = 0;
  int nfail = 0;

  // Cycle counts of each pulse output being high (a clean pulse adds exactly 1).
  int vld_d = 0, ferr_d = 0, perr_d = 0, done_d = 0;
  int vld_p = 0, ferr_p = 0, perr_p = 0, done_p = 0;
  always @(negedge clk) begin
    if (rx_valid_d)      vld_d++;
    if (rx_frame_err_d)  ferr_d++;
    if (rx_parity_err_d) perr_d++;
    if (tx_done_d)       done_d++;
    if (rx_valid_p)      vld_p++;
    if (rx_frame_err_p)  ferr_p++;
    if (rx_parity_err_p) perr_p++;
    if (tx_done_p)       done_p++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_d = v;
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_p : tx_d;
  endfunction

  // Drive one frame on the chosen rx line, starting at a falling clock edge.
  task automatic send_rx(input bit sel, input int c, input int nbits, input logic [31:0] data,
                         input bit has_par, input logic par, input logic stop);
    set_rx(sel, 1'b0);
    wait_neg(c);
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, data[i]);
      wait_neg(c);
    end
    if (has_par) begin
      set_rx(sel, par);
      wait_neg(c);
    end
    set_rx(sel, stop);
    wait_neg(c);
    set_rx(sel, 1'b1);
  endtask

  task automatic pulse_start(input bit sel, input logic [7:0] d);
    if (sel) begin tx_start_p = 1'b1; tx_data_p = d; end
    else     begin tx_start_d = 1'b1; tx_data_d = d; end
    @(negedge clk);
    if (sel) tx_start_p = 1'b0;
    else     tx_start_d = 1'b0;
  endtask

  // Bench receiver: find the start bit, then sample the middle of every bit.
  // v[0] is the start bit. Returns at the middle of the last bit.
  task automatic decode_tx(input bit sel, input int c, input int nbits,
                           output logic [39:0] v, output bit ok);
    int w;
    int pos;
    w = 0;
    pos = 0;
    v = '0;
    ok = 1'b1;
    while (tx_of(sel) !== 1'b0 && w < 3 * c) begin
      @(negedge clk);
      w++;
    end
    if (tx_of(sel) !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int k = 0; k < nbits; k++) begin
      while (pos < k * c + c / 2) begin
        @(negedge clk);
        pos++;
      end
      v[k] = tx_of(sel);
    end
  endtask

  task automatic cycles_to_low(input bit sel, input int limit, output int n);
    n = 0;
    while (tx_of(sel) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_low(input bit sel, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (tx_of(sel) === 1'b0) n++;
    end
  endtask

  initial begin
    logic [39:0] v;
    logic [39:0] exp;
    bit          ok;
    int          b_v, b_f, b_p, b_d, n;
    logic [14:0] rdata, last_good;
    logic [7:0]  td;
    logic        par, stop;
    bit          bad_par;

    // Reset held for five cycles with rx idle
    reset_n = 1'b0;
    rx_d = 1'b1; rx_p = 1'b1;
    tx_start_d = 1'b0; tx_start_p = 1'b0;
    tx_data_d = '0; tx_data_p = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_tx", tx_d, 1'b1);
      chk("reset_rx_valid", rx_valid_d, 1'b0);
      chk("reset_tx_busy", tx_busy_d, 1'b0);
    end
    chk("reset_rx_data", rx_data_d, 15'h0);
    chk("reset_tx_done", tx_done_d, 1'b0);
    reset_n = 1'b1;
    wait_neg(3);

    // Default frame 15'h5555
    b_v = vld_d; b_f = ferr_d; b_p = perr_d;
    send_rx(1'b0, CD, 15, 32'h5555, 1'b0, 1'b0, 1'b1);
    chk("rx5555_valid", vld_d - b_v, 1);
    chk("rx5555_ferr", ferr_d - b_f, 0);
    chk("rx5555_perr", perr_d - b_p, 0);
    chk("rx5555_data", rx_data_d, 15'h5555);

    // Transmit A5: 0,1,0,1,0,0,1,0,1,1 one bit per CD clocks
    b_d = done_d;
    pulse_start(1'b0, 8'hA5);
    chk("txA5_busy", tx_busy_d, 1'b1);
    decode_tx(1'b0, CD, 10, v, ok);
    chk("txA5_seen", ok, 1'b1);
    chk("txA5_bits", v[9:0], 10'b1_1010_0101_0);
    wait_neg(CD);
    chk("txA5_done_once", done_d - b_d, 1);
    chk("txA5_idle_busy", tx_busy_d, 1'b0);
    chk("txA5_idle_line", tx_d, 1'b1);

    // 100 ns glitch is rejected
    b_v = vld_d; b_f = ferr_d; b_p = perr_d;
    rx_d = 1'b0;
    wait_neg(5);
    rx_d = 1'b1;
    wait_neg(2 * CD);
    chk("glitch_flags", (vld_d - b_v) + (ferr_d - b_f) + (perr_d - b_p), 0);

    // Stop bit low: framing error, rx_data untouched
    send_rx(1'b0, CD, 15, 32'h2A3C, 1'b0, 1'b0, 1'b0);
    wait_neg(2 * CD);
    chk("ferr_pulse", ferr_d - b_f, 1);
    chk("ferr_valid", vld_d - b_v, 0);
    chk("ferr_data_kept", rx_data_d, 15'h5555);

    // Parity instance: 15'h0001 with wrong then right even parity, then both faults
    b_v = vld_p; b_f = ferr_p; b_p = perr_p;
    send_rx(1'b1, CP, 15, 32'h0001, 1'b1, 1'b0, 1'b1);
    chk("par_bad_perr", perr_p - b_p, 1);
    chk("par_bad_valid", vld_p - b_v, 0);
    chk("par_bad_data", rx_data_p, 15'h0);
    send_rx(1'b1, CP, 15, 32'h0001, 1'b1, 1'b1, 1'b1);
    chk("par_ok_valid", vld_p - b_v, 1);
    chk("par_ok_perr", perr_p - b_p, 1);
    chk("par_ok_data", rx_data_p, 15'h0001);
    send_rx(1'b1, CP, 15, 32'h0001, 1'b1, 1'b0, 1'b0);
    wait_neg(2 * CP);
    chk("both_ferr", ferr_p - b_f, 1);
    chk("both_no_perr", perr_p - b_p, 1);
    chk("both_data", rx_data_p, 15'h0001);

    // Random receive frames on the parity instance; good frames run back to back
    last_good = 15'h0001;
    for (int i = 0; i < 10; i++) begin
      rdata   = 15'($urandom);
      bad_par = (i >= 2) && ($urandom_range(0, 3) == 0);
      stop    = (i < 2) || ($urandom_range(0, 3) != 0);
      par     = (^rdata) ^ bad_par;
      b_v = vld_p; b_f = ferr_p; b_p = perr_p;
      send_rx(1'b1, CP, 15, {17'b0, rdata}, 1'b1, par, stop);
      if (stop && !bad_par) last_good = rdata;
      chk("rand_rx_valid", vld_p - b_v, (stop && !bad_par) ? 1 : 0);
      chk("rand_rx_ferr", ferr_p - b_f, stop ? 0 : 1);
      chk("rand_rx_perr", perr_p - b_p, (stop && bad_par) ? 1 : 0);
      chk("rand_rx_data", rx_data_p, last_good);
      if (!stop) wait_neg(2 * CP);
    end

    // Random transmit frames on the parity instance
    for (int i = 0; i < 6; i++) begin
      td = 8'($urandom);
      b_d = done_p;
      pulse_start(1'b1, td);
      decode_tx(1'b1, CP, 11, v, ok);
      exp = {29'b0, 1'b1, ^td, td, 1'b0};
      chk("rand_tx_seen", ok, 1'b1);
      chk("rand_tx_bits", v, exp);
      wait_neg(CP);
      chk("rand_tx_done", done_p - b_d, 1);
    end

    // tx_start re-pulsed mid-frame is ignored
    b_d = done_d;
    pulse_start(1'b0, 8'h3C);
    fork
      decode_tx(1'b0, CD, 10, v, ok);
      begin
        wait_neg(3 * CD);
        tx_start_d = 1'b1;
        tx_data_d  = 8'hFF;
        wait_neg(1);
        tx_start_d = 1'b0;
      end
    join
    chk("repulse_seen", ok, 1'b1);
    chk("repulse_bits", v[9:0], {1'b1, 8'h3C, 1'b0});
    count_low(1'b0, 2 * CD, n);
    chk("repulse_no_second", n, 0);
    chk("repulse_done", done_d - b_d, 1);
    chk("repulse_busy", tx_busy_d, 1'b0);

    // tx_start held high: two frames with no idle time between them
    b_d = done_d;
    tx_start_d = 1'b1;
    tx_data_d  = 8'h81;
    @(negedge clk);
    tx_data_d = 8'h5E;
    decode_tx(1'b0, CD, 10, v, ok);
    chk("b2b_first_seen", ok, 1'b1);
    chk("b2b_first_bits", v[9:0], {1'b1, 8'h81, 1'b0});
    cycles_to_low(1'b0, 2 * CD, n);
    tx_start_d = 1'b0;
    chk("b2b_gap", n, CD - CD / 2);
    decode_tx(1'b0, CD, 10, v, ok);
    chk("b2b_second_seen", ok, 1'b1);
    chk("b2b_second_bits", v[9:0], {1'b1, 8'h5E, 1'b0});
    count_low(1'b0, 2 * CD, n);
    chk("b2b_no_third", n, 0);
    chk("b2b_done_count", done_d - b_d, 2);

    // Reset mid-frame forces the line high at once
    pulse_start(1'b0, 8'h00);
    wait_neg(CD + CD / 2);
    chk("midrst_pre_line", tx_d, 1'b0);
    chk("midrst_pre_busy", tx_busy_d, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_line", tx_d, 1'b1);
    chk("midrst_busy", tx_busy_d, 1'b0);
    chk("midrst_rx_data", rx_data_d, 15'h0);
    @(negedge clk);
    reset_n = 1'b1;
    count_low(1'b0, 2 * CD, n);
    chk("midrst_stays_idle", n, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
